// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : Bus bundle between the I/D cache fill FSMs, the D-cache
//               write-through path, the shared memory port and the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
  logic        i_req;
  logic [15:0] i_addr;
  logic        i_gnt;
  logic        i_data_valid;

  logic        d_req;
  logic [15:0] d_addr;
  logic        d_gnt;
  logic        d_data_valid;

  logic        d_wr_req;
  logic [15:0] d_wr_addr;
  logic [15:0] d_wr_data;
  logic        d_wr_ack;

  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic        mem_data_valid;

  // Arbiter side
  modport slave (
    input  i_req, i_addr, d_req, d_addr,
    input  d_wr_req, d_wr_addr, d_wr_data,
    input  mem_data_valid,
    output i_gnt, i_data_valid, d_gnt, d_data_valid, d_wr_ack,
    output mem_en, mem_wr, mem_addr, mem_data_in
  );

  // Requester / memory side
  modport master (
    output i_req, i_addr, d_req, d_addr,
    output d_wr_req, d_wr_addr, d_wr_data,
    output mem_data_valid,
    input  i_gnt, i_data_valid, d_gnt, d_data_valid, d_wr_ack,
    input  mem_en, mem_wr, mem_addr, mem_data_in
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one pipelined memory port between I-cache fills,
//               D-cache fills and D-cache write-through stores.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter (
  input  wire logic    clk,
  input  wire logic    rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  localparam logic       LS_I    = 1'b0;
  localparam logic       LS_D    = 1'b1;
  localparam logic [2:0] OUT_MAX = 3'd7;

  state_e      state_q, state_d;
  logic [2:0]  outstanding_q, outstanding_d;
  logic        last_served_q, last_served_d;

  logic        w_i_gnt, w_d_gnt, w_i_dv, w_d_dv, w_ack;
  logic        w_mem_en, w_mem_wr;
  logic [15:0] w_mem_addr, w_mem_data;
  logic        w_data_ret;
  logic        w_rd_issue;

  // A return only counts when a read is actually in flight; strays are dropped.
  assign w_data_ret = bus.mem_data_valid && (outstanding_q != 3'd0);
  assign w_rd_issue = w_mem_en && !w_mem_wr;

  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    w_i_gnt       = 1'b0;
    w_d_gnt       = 1'b0;
    w_i_dv        = 1'b0;
    w_d_dv        = 1'b0;
    w_ack         = 1'b0;
    w_mem_en      = 1'b0;
    w_mem_wr      = 1'b0;
    w_mem_addr    = 16'd0;
    w_mem_data    = 16'd0;

    case (state_q)
      ST_IDLE: begin
        if (bus.d_wr_req) begin
          state_d = ST_WRITE;
        end else if (bus.d_req && bus.i_req) begin
          state_d = (last_served_q == LS_I) ? ST_GNT_D : ST_GNT_I;
        end else if (bus.d_req) begin
          state_d = ST_GNT_D;
        end else if (bus.i_req) begin
          state_d = ST_GNT_I;
        end
      end

      ST_WRITE: begin
        w_mem_en   = 1'b1;
        w_mem_wr   = 1'b1;
        w_mem_addr = bus.d_wr_addr;
        w_mem_data = bus.d_wr_data;
        w_ack      = 1'b1;
        state_d    = ST_IDLE;
      end

      ST_GNT_I: begin
        w_i_gnt  = 1'b1;
        w_mem_en = bus.i_req && (outstanding_q != OUT_MAX);
        if (w_mem_en) begin
          w_mem_addr = bus.i_addr;
        end
        w_i_dv = w_data_ret;
        // Burst ends only once the requester is done and every read has returned.
        if (!bus.i_req && (outstanding_q == 3'd0)) begin
          state_d       = ST_IDLE;
          last_served_d = LS_I;
        end
      end

      ST_GNT_D: begin
        w_d_gnt  = 1'b1;
        w_mem_en = bus.d_req && (outstanding_q != OUT_MAX);
        if (w_mem_en) begin
          w_mem_addr = bus.d_addr;
        end
        w_d_dv = w_data_ret;
        if (!bus.d_req && (outstanding_q == 3'd0)) begin
          state_d       = ST_IDLE;
          last_served_d = LS_D;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (w_rd_issue && !w_data_ret) begin
      outstanding_d = outstanding_q + 3'd1;
    end else if (!w_rd_issue && w_data_ret) begin
      outstanding_d = outstanding_q - 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      outstanding_q <= 3'd0;
      last_served_q <= LS_I;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      last_served_q <= last_served_d;
    end
  end

  assign bus.i_gnt        = w_i_gnt;
  assign bus.d_gnt        = w_d_gnt;
  assign bus.i_data_valid = w_i_dv;
  assign bus.d_data_valid = w_d_dv;
  assign bus.d_wr_ack     = w_ack;
  assign bus.mem_en       = w_mem_en;
  assign bus.mem_wr       = w_mem_wr;
  assign bus.mem_addr     = w_mem_addr;
  assign bus.mem_data_in  = w_mem_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed scenarios plus randomized traffic for mem_arbiter,
//               compared cycle by cycle against an ownership-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int OWN_NONE = 0;
  localparam int OWN_I    = 1;
  localparam int OWN_D    = 2;
  localparam int OWN_W    = 3;

  logic clk;
  logic rst;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns memory, how many reads are in flight, who went last
  int  m_owner;
  int  m_out;
  bit  m_last_d;

  // Memory model: fixed latency, one return per issued read
  int  cyc;
  int  lat;
  bit  mem_on;
  bit  stray;
  int  ret_q[$];

  // Requester models
  int          i_left, d_left;
  logic [15:0] i_ad, d_ad;
  bit          w_pend;
  logic [15:0] w_addr, w_data;

  // Observations of the DUT
  int          i_dv_cnt, d_dv_cnt, ack_cnt, en_cnt;
  logic [15:0] addr_log[$];
  logic [15:0] wr_seen_addr, wr_seen_data;
  int          i_skip, d_skip;
  bit          prev_ig, prev_dg;

  function automatic logic [6:0] dut_ctl();
    return {bus.i_gnt, bus.d_gnt, bus.i_data_valid, bus.d_data_valid,
            bus.d_wr_ack, bus.mem_en, bus.mem_wr};
  endfunction

  function automatic logic [15:0] log_at(input int k);
    if (k < addr_log.size()) return addr_log[k];
    return 16'hxxxx;
  endfunction

  function automatic bit busy();
    return (i_left > 0) || (d_left > 0) || w_pend || (m_owner != OWN_NONE) || (ret_q.size() > 0);
  endfunction

  task automatic drive();
    bus.i_req     = (i_left > 0);
    bus.i_addr    = i_ad;
    bus.d_req     = (d_left > 0);
    bus.d_addr    = d_ad;
    bus.d_wr_req  = w_pend;
    bus.d_wr_addr = w_addr;
    bus.d_wr_data = w_data;
  endtask

  task automatic clear_obs();
    i_dv_cnt = 0; d_dv_cnt = 0; ack_cnt = 0; en_cnt = 0;
    addr_log.delete();
    wr_seen_addr = 16'd0; wr_seen_data = 16'd0;
  endtask

  // One clock cycle: entered and left at 1 time unit after a rising edge.
  task automatic cycle();
    bit          due, ret, iss, req_x, e_en, e_wr;
    logic [15:0] e_addr, e_data;
    logic [6:0]  e_ctl;
    int          old_out;

    drive();
    due = (ret_q.size() > 0) && (ret_q[0] <= cyc);
    if (due) void'(ret_q.pop_front());
    bus.mem_data_valid = due || stray;
    #2;

    ret    = bus.mem_data_valid && (m_out > 0);
    e_en   = 1'b0; e_wr = 1'b0; e_addr = 16'd0; e_data = 16'd0;
    if (m_owner == OWN_W) begin
      e_en = 1'b1; e_wr = 1'b1; e_addr = w_addr; e_data = w_data;
    end else if (m_owner == OWN_I || m_owner == OWN_D) begin
      req_x = (m_owner == OWN_I) ? (i_left > 0) : (d_left > 0);
      e_en  = req_x && (m_out < 7);
      if (e_en) e_addr = (m_owner == OWN_I) ? i_ad : d_ad;
    end
    e_ctl = {m_owner == OWN_I, m_owner == OWN_D, (m_owner == OWN_I) && ret,
             (m_owner == OWN_D) && ret, m_owner == OWN_W, e_en, e_wr};

    check("ctl{ig,dg,idv,ddv,ack,en,wr}", {25'd0, dut_ctl()}, {25'd0, e_ctl});
    check("mem_addr", {16'd0, bus.mem_addr}, {16'd0, e_addr});
    check("mem_data_in", {16'd0, bus.mem_data_in}, {16'd0, e_data});

    if (bus.i_data_valid) i_dv_cnt++;
    if (bus.d_data_valid) d_dv_cnt++;
    if (bus.d_wr_ack) begin
      ack_cnt++; wr_seen_addr = bus.mem_addr; wr_seen_data = bus.mem_data_in;
    end
    if (bus.mem_en) begin
      en_cnt++; addr_log.push_back(bus.mem_addr);
    end
    if (bus.d_gnt && !prev_dg && bus.i_req) i_skip++;
    if (bus.i_gnt && !prev_ig && bus.d_req) d_skip++;
    if (bus.i_gnt && !prev_ig) begin
      check("fair_i_wait", {31'd0, i_skip <= 1}, 32'd1); i_skip = 0;
    end
    if (bus.d_gnt && !prev_dg) begin
      check("fair_d_wait", {31'd0, d_skip <= 1}, 32'd1); d_skip = 0;
    end
    prev_ig = bus.i_gnt;
    prev_dg = bus.d_gnt;

    iss = e_en && !e_wr;
    if (rst) begin
      m_owner = OWN_NONE; m_out = 0; m_last_d = 1'b0;
    end else begin
      old_out = m_out;
      if (mem_on && iss) ret_q.push_back(cyc + lat);
      m_out = m_out + int'(iss) - int'(ret);
      case (m_owner)
        OWN_NONE: begin
          if (w_pend)                      m_owner = OWN_W;
          else if (d_left > 0 && i_left > 0) m_owner = m_last_d ? OWN_I : OWN_D;
          else if (d_left > 0)             m_owner = OWN_D;
          else if (i_left > 0)             m_owner = OWN_I;
        end
        OWN_W: begin
          m_owner = OWN_NONE;
          w_pend  = 1'b0;
        end
        OWN_I: begin
          if (iss) begin i_left--; i_ad = i_ad + 16'd2; end
          else if (i_left == 0 && old_out == 0) begin m_owner = OWN_NONE; m_last_d = 1'b0; end
        end
        OWN_D: begin
          if (iss) begin d_left--; d_ad = d_ad + 16'd2; end
          else if (d_left == 0 && old_out == 0) begin m_owner = OWN_NONE; m_last_d = 1'b1; end
        end
        default: m_owner = OWN_NONE;
      endcase
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic apply_reset(input int hold);
    rst = 1'b1;
    #1;
    check("rst_ctl", {25'd0, dut_ctl()}, 32'd0);
    check("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    check("rst_mem_data_in", {16'd0, bus.mem_data_in}, 32'd0);
    i_left = 0; d_left = 0; w_pend = 1'b0;
    m_owner = OWN_NONE; m_out = 0; m_last_d = 1'b0;
    i_skip = 0; d_skip = 0; prev_ig = 1'b0; prev_dg = 1'b0;
    repeat (hold) cycle();
    rst = 1'b0;
  endtask

  task automatic run_until_quiet(input int limit);
    int n;
    n = 0;
    while (busy() && n < limit) begin
      cycle();
      n++;
    end
    check("quiet_timeout", {31'd0, busy()}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    cyc = 0; lat = 4; mem_on = 1'b1; stray = 1'b0;
    i_left = 0; d_left = 0; i_ad = 16'd0; d_ad = 16'd0;
    w_pend = 1'b0; w_addr = 16'd0; w_data = 16'd0;
    m_owner = OWN_NONE; m_out = 0; m_last_d = 1'b0;
    i_skip = 0; d_skip = 0; prev_ig = 1'b0; prev_dg = 1'b0;
    clear_obs();
    drive();
    bus.mem_data_valid = 1'b0;
    @(posedge clk);
    #1;
    apply_reset(2);

    // Simultaneous fills right after reset: D wins the tie, I follows
    clear_obs();
    i_left = 2; i_ad = 16'h4000;
    d_left = 2; d_ad = 16'h5000;
    cycle();
    check("tie_d_gnt", {31'd0, bus.d_gnt}, 32'd1);
    check("tie_i_gnt", {31'd0, bus.i_gnt}, 32'd0);
    run_until_quiet(60);
    check("tie_order0", {16'd0, log_at(0)}, 32'h5000);
    check("tie_order2", {16'd0, log_at(2)}, 32'h4000);

    // Eight-read I fill with latency 4
    clear_obs();
    lat = 4;
    i_left = 8; i_ad = 16'h1230;
    run_until_quiet(60);
    check("fill_issues", addr_log.size(), 32'd8);
    for (int k = 0; k < 8; k++) check("fill_addr", {16'd0, log_at(k)}, 32'h1230 + 32'(2 * k));
    check("fill_i_dv", i_dv_cnt, 32'd8);

    // Write-through raised mid I fill waits for the next arbitration
    clear_obs();
    i_left = 6; i_ad = 16'h2000;
    repeat (3) cycle();
    w_pend = 1'b1; w_addr = 16'h00F0; w_data = 16'hBEEF;
    run_until_quiet(60);
    check("wr_ack_pulses", ack_cnt, 32'd1);
    check("wr_addr", {16'd0, wr_seen_addr}, 32'h00F0);
    check("wr_data", {16'd0, wr_seen_data}, 32'hBEEF);
    check("wr_after_fill", {16'd0, log_at(6)}, 32'h00F0);
    clear_obs();
    i_left = 1; i_ad = 16'h3000;
    d_left = 1; d_ad = 16'h3100;
    run_until_quiet(40);
    check("ls_kept_by_write", {16'd0, log_at(0)}, 32'h3100);

    // Request drops with reads still in flight
    clear_obs();
    lat = 3;
    i_left = 5; i_ad = 16'h6000;
    run_until_quiet(60);
    check("drain_i_dv", i_dv_cnt, 32'd5);
    lat = 4;

    // Outstanding cap with a silent memory, then strays while idle
    clear_obs();
    mem_on = 1'b0;
    d_left = 9; d_ad = 16'h7000;
    repeat (12) cycle();
    check("cap_issues", en_cnt, 32'd7);
    check("cap_d_gnt", {31'd0, bus.d_gnt}, 32'd1);
    apply_reset(1);
    mem_on = 1'b1;
    clear_obs();
    stray = 1'b1;
    repeat (4) cycle();
    stray = 1'b0;
    check("stray_en", en_cnt, 32'd0);
    check("stray_dv", i_dv_cnt + d_dv_cnt, 32'd0);
    d_left = 2; d_ad = 16'h7100;
    run_until_quiet(40);
    check("post_stray_d_dv", d_dv_cnt, 32'd2);

    // Reset in the middle of a D burst with two reads outstanding
    d_left = 4; d_ad = 16'h8000;
    repeat (3) cycle();
    clear_obs();
    apply_reset(1);
    repeat (6) cycle();
    check("late_dv", i_dv_cnt + d_dv_cnt, 32'd0);
    check("late_drained", ret_q.size(), 32'd0);

    // Randomized traffic
    for (int blk = 0; blk < 6; blk++) begin
      lat = ($urandom_range(0, 1) == 0) ? 4 : 10;
      for (int n = 0; n < 500; n++) begin
        if (i_left == 0 && $urandom_range(0, 5) == 0) begin
          i_left = $urandom_range(1, 8); i_ad = 16'($urandom) & 16'hFFFE;
        end
        if (d_left == 0 && $urandom_range(0, 5) == 0) begin
          d_left = $urandom_range(1, 8); d_ad = 16'($urandom) & 16'hFFFE;
        end
        if (!w_pend && $urandom_range(0, 15) == 0) begin
          w_pend = 1'b1; w_addr = 16'($urandom); w_data = 16'($urandom);
        end
        stray = ($urandom_range(0, 63) == 0);
        if (blk == 3 && n == 250) begin
          stray = 1'b0;
          apply_reset(1);
        end
        cycle();
      end
      stray = 1'b0;
      run_until_quiet(300);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
